montgomery_constant_streamer: RTL and testbench
===============================================

// Module: montgomery_constant_streamer
// PURPOSE
//  Producer side of the N/k constant-stream handshake used by montgomery_reduce and its wrappers.
//  Holds modulus N and Montgomery constant k as REGISTER_SIZE-bit blocks, loaded once over a serial load port.
//  Presents the current block of each constant; a 1-cycle consumed_*_in pulse advances to the next block, LSB block first.
//  Each constant wraps independently after its last block, so the consumer sees an endless cyclic stream.
// PARAMETERS
//  REGISTER_SIZE  32    width of one block
//  BITS_IN_NUM    4096  bits per constant; NUM_BLOCKS = BITS_IN_NUM/REGISTER_SIZE (must divide exactly)
// PORTS
//  clk_in             in   1              clock; all logic on posedge
//  rst_in             in   1              synchronous reset, active-low (0 = reset)
//  load_start_in      in   1              pulse: discard stored constants, restart loading
//  load_valid_in      in   1              load_block_in valid this cycle
//  load_sel_in        in   1              0 = block belongs to N, 1 = block belongs to k
//  load_block_in      in   REGISTER_SIZE  constant block, LSB block first
//  consumed_N_in      in   1              consumer took current N block
//  consumed_k_in      in   1              consumer took current k block
//  N_out              out  REGISTER_SIZE  current N block
//  k_out              out  REGISTER_SIZE  current k block
//  ready_out          out  1              both constants fully loaded
//  underrun_out       out  1              sticky: a consume pulse arrived while ready_out=0
// BEHAVIOUR
//  - Storage: two arrays, NUM_BLOCKS x REGISTER_SIZE each. Per constant: write ptr wp_N/wp_k, read ptr rp_N/rp_k, loaded flag.
//  - States: EMPTY -> LOADING on first load_valid_in; LOADING -> READY when both loaded flags are set;
//    any state -> EMPTY on load_start_in.
//  - Reset (rst_in=0): all ptrs=0, flags=0, state=EMPTY, underrun_out=0. N_out=k_out=0, ready_out=0. Array contents are don't-care.
//  - Load: load_valid_in=1 writes load_block_in to the array chosen by load_sel_in at its wp, then wp++.
//    At wp==NUM_BLOCKS-1 the write sets that constant's loaded flag. Writes to an already-loaded constant are dropped.
//    N and k loads may interleave arbitrarily.
//  - ready_out is registered: it rises the cycle after the write that completes the second constant.
//  - Outputs: N_out=mem_N[rp_N] and k_out=mem_k[rp_k] while ready_out=1; both read 0 otherwise.
//    Outputs come straight from registered pointers; no combinational path from consumed_*_in.
//  - Consume: consumed_X_in=1 with ready_out=1 advances rp_X; the next block is visible the following cycle.
//    At rp_X==NUM_BLOCKS-1, rp_X wraps to 0.
//  - consumed_N_in and consumed_k_in are independent; both in one cycle advance both pointers.
//  - consumed_*_in with ready_out=0: ignored, pointers unchanged, underrun_out set. underrun_out clears only on reset or load_start_in.
//  - load_start_in wins over load_valid_in and consume pulses in the same cycle (that load block is dropped).
//    It clears ptrs and flags; ready_out falls the next cycle.
//  - Reset in mid-load or mid-stream: everything returns to reset values; nothing resumes.
// CONFIGURATION
//  MONT_CONST_PASS_CNT_EN defined: adds output N_pass_cnt_out [15:0] and k_pass_cnt_out [15:0].
//    Each increments when its rp wraps NUM_BLOCKS-1 -> 0, saturates at 16'hFFFF, and clears on reset/load_start_in.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING (REGISTER_SIZE=32, BITS_IN_NUM=128, NUM_BLOCKS=4)
//  - Load N=1,2,3,4 then k=A,B,C,D -> ready_out=1 one cycle after the D write; N_out=1, k_out=A.
//  - Pulse consumed_N_in 5 times -> N_out sequence 2,3,4,1,2; k_out stays A.
//    With MONT_CONST_PASS_CNT_EN: N_pass_cnt_out=1, k_pass_cnt_out=0.
//  - Interleave N/k loads, then pulse both consumes every cycle for 8 cycles -> N_out/k_out track 1/A,2/B,3/C,4/D,1/A...
//  - Pulse consumed_k_in before loading finishes -> underrun_out=1, rp_k=0; after load completes, k_out=A.
//  - In READY, load_start_in together with consumed_N_in -> next cycle ready_out=0, N_out=0, underrun_out=0.
//    Reload N=5..8 and k=E..H -> N_out=5.
//  - Load a 5th N block after N is complete -> dropped, N_out still 1. Assert rst_in=0 mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/montgomery_constant_streamer.sv
// Streams the Montgomery constants N and k as cyclic REGISTER_SIZE-bit blocks, LSB block first.
// Optional define MONT_CONST_PASS_CNT_EN adds per-constant saturating wrap counters.

module mcs_const_chan #(
    parameter int REGISTER_SIZE = 32,
    parameter int NUM_BLOCKS    = 128
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_clr,
    input  logic                     i_wr,
    input  logic [REGISTER_SIZE-1:0] i_wr_data,
    input  logic                     i_adv,
    output logic [REGISTER_SIZE-1:0] o_rd_data,
    output logic                     o_loaded_nxt
`ifdef MONT_CONST_PASS_CNT_EN
    ,
    output logic [15:0]              o_pass_cnt
`endif
);
    localparam int PW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam logic [PW-1:0] LAST = PW'(NUM_BLOCKS - 1);

    logic [REGISTER_SIZE-1:0] r_mem [NUM_BLOCKS];
    logic [PW-1:0]            r_wp;
    logic [PW-1:0]            r_rp;
    logic                     r_loaded;
    logic                     w_wr;
    logic                     w_wp_last;
    logic                     w_rp_last;

    // Writes past the last block of an already complete constant are dropped.
    assign w_wr         = i_wr & ~r_loaded & ~i_clr;
    assign w_wp_last    = (r_wp == LAST);
    assign w_rp_last    = (r_rp == LAST);
    assign o_loaded_nxt = ~i_clr & (r_loaded | (w_wr & w_wp_last));
    assign o_rd_data    = r_mem[r_rp];

    always_ff @(posedge i_clk) begin
        if (w_wr)
            r_mem[r_wp] <= i_wr_data;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            r_wp     <= '0;
            r_rp     <= '0;
            r_loaded <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wp <= w_wp_last ? '0 : r_wp + PW'(1);
                if (w_wp_last)
                    r_loaded <= 1'b1;
            end
            if (i_adv)
                r_rp <= w_rp_last ? '0 : r_rp + PW'(1);
        end
    end

`ifdef MONT_CONST_PASS_CNT_EN
    logic [15:0] r_pass;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr)
            r_pass <= '0;
        else if (i_adv && w_rp_last && r_pass != 16'hFFFF)
            r_pass <= r_pass + 16'd1;
    end

    assign o_pass_cnt = r_pass;
`endif
endmodule

module montgomery_constant_streamer #(
    parameter int REGISTER_SIZE = 32,
    parameter int BITS_IN_NUM   = 4096
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     load_start_in,
    input  logic                     load_valid_in,
    input  logic                     load_sel_in,
    input  logic [REGISTER_SIZE-1:0] load_block_in,
    input  logic                     consumed_N_in,
    input  logic                     consumed_k_in,
    output logic [REGISTER_SIZE-1:0] N_out,
    output logic [REGISTER_SIZE-1:0] k_out,
    output logic                     ready_out,
    output logic                     underrun_out
`ifdef MONT_CONST_PASS_CNT_EN
    ,
    output logic [15:0]              N_pass_cnt_out,
    output logic [15:0]              k_pass_cnt_out
`endif
);
    localparam int NUM_BLOCKS = BITS_IN_NUM / REGISTER_SIZE;
    localparam int NCH        = 2;

    typedef enum logic [1:0] {S_EMPTY, S_LOADING, S_READY} state_t;

    state_t                             r_state;
    logic                               r_ready;
    logic                               r_underrun;
    logic [NCH-1:0]                     w_wr;
    logic [NCH-1:0]                     w_consume;
    logic [NCH-1:0]                     w_adv;
    logic [NCH-1:0]                     w_loaded_nxt;
    logic [NCH-1:0][REGISTER_SIZE-1:0]  w_rd;
    logic                               w_both;
`ifdef MONT_CONST_PASS_CNT_EN
    logic [NCH-1:0][15:0]               w_pass;
`endif

    // Channel 0 carries N, channel 1 carries k.
    assign w_wr      = {load_valid_in & load_sel_in, load_valid_in & ~load_sel_in};
    assign w_consume = {consumed_k_in, consumed_N_in};
    assign w_adv     = w_consume & {NCH{r_ready & ~load_start_in}};
    assign w_both    = &w_loaded_nxt;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        mcs_const_chan #(
            .REGISTER_SIZE (REGISTER_SIZE),
            .NUM_BLOCKS    (NUM_BLOCKS)
        ) u_ch (
            .i_clk        (clk_in),
            .i_rst_n      (rst_in),
            .i_clr        (load_start_in),
            .i_wr         (w_wr[g]),
            .i_wr_data    (load_block_in),
            .i_adv        (w_adv[g]),
            .o_rd_data    (w_rd[g]),
            .o_loaded_nxt (w_loaded_nxt[g])
`ifdef MONT_CONST_PASS_CNT_EN
            ,
            .o_pass_cnt   (w_pass[g])
`endif
        );
    end

    // ready rises on the edge that stores the final block of the second constant.
    always_ff @(posedge clk_in) begin
        if (!rst_in || load_start_in) begin
            r_state    <= S_EMPTY;
            r_ready    <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if ((|w_consume) && !r_ready)
                r_underrun <= 1'b1;
            case (r_state)
                S_EMPTY: begin
                    if (load_valid_in) begin
                        r_state <= w_both ? S_READY : S_LOADING;
                        r_ready <= w_both;
                    end
                end
                S_LOADING: begin
                    if (w_both) begin
                        r_state <= S_READY;
                        r_ready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign N_out        = r_ready ? w_rd[0] : '0;
    assign k_out        = r_ready ? w_rd[1] : '0;
    assign ready_out    = r_ready;
    assign underrun_out = r_underrun;

`ifdef MONT_CONST_PASS_CNT_EN
    assign N_pass_cnt_out = w_pass[0];
    assign k_pass_cnt_out = w_pass[1];
`endif
endmodule

// File: tb/tb_montgomery_constant_streamer.sv
// Bench for montgomery_constant_streamer (NUM_BLOCKS=4) against a queue-based reference model.
// Pass-counter ports are checked when MONT_CONST_PASS_CNT_EN is defined.

module tb_montgomery_constant_streamer;
    localparam int RS = 32;
    localparam int BN = 128;
    localparam int NB = BN / RS;
    localparam int VW = 2 * RS + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ls = 1'b0;
    logic          lv = 1'b0;
    logic          lsel = 1'b0;
    logic [RS-1:0] lb = '0;
    logic          cn_i = 1'b0;
    logic          ck_i = 1'b0;
    logic [RS-1:0] N_out;
    logic [RS-1:0] k_out;
    logic          ready_out;
    logic          underrun_out;
`ifdef MONT_CONST_PASS_CNT_EN
    logic [15:0]   N_pass_cnt_out;
    logic [15:0]   k_pass_cnt_out;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: blocks accepted so far, consume counts, ready/underrun flags.
    logic [RS-1:0] mn[$];
    logic [RS-1:0] mk[$];
    int            mcn;
    int            mck;
    bit            mrdy;
    bit            mund;

    montgomery_constant_streamer #(.REGISTER_SIZE(RS), .BITS_IN_NUM(BN)) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .load_start_in (ls),
        .load_valid_in (lv),
        .load_sel_in   (lsel),
        .load_block_in (lb),
        .consumed_N_in (cn_i),
        .consumed_k_in (ck_i),
        .N_out         (N_out),
        .k_out         (k_out),
        .ready_out     (ready_out),
        .underrun_out  (underrun_out)
`ifdef MONT_CONST_PASS_CNT_EN
        ,
        .N_pass_cnt_out(N_pass_cnt_out),
        .k_pass_cnt_out(k_pass_cnt_out)
`endif
    );

    always #5 clk = ~clk;

    function automatic void model_clear();
        mn.delete();
        mk.delete();
        mcn  = 0;
        mck  = 0;
        mrdy = 1'b0;
        mund = 1'b0;
    endfunction

    function automatic logic [VW-1:0] expv();
        logic [RS-1:0] en;
        logic [RS-1:0] ek;
        en = '0;
        ek = '0;
        if (mrdy) begin
            en = mn[mcn % NB];
            ek = mk[mck % NB];
        end
        return {en, ek, mrdy, mund};
    endfunction

    function automatic logic [15:0] exp_pass(input int c);
        return (c / NB > 65535) ? 16'hFFFF : 16'(c / NB);
    endfunction

    task automatic step(input bit s, input bit v, input bit sel, input logic [RS-1:0] d,
                        input bit c_n, input bit c_k);
        ls = s; lv = v; lsel = sel; lb = d; cn_i = c_n; ck_i = c_k;
        @(posedge clk);
        if (s) begin
            model_clear();
        end else begin
            if ((c_n || c_k) && !mrdy) mund = 1'b1;
            if (mrdy) begin
                if (c_n) mcn++;
                if (c_k) mck++;
            end
            if (v) begin
                if (!sel && mn.size() < NB) mn.push_back(d);
                else if (sel && mk.size() < NB) mk.push_back(d);
            end
            mrdy = (mn.size() == NB) && (mk.size() == NB);
        end
        #1;
        ls = 1'b0; lv = 1'b0; cn_i = 1'b0; ck_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        model_clear();
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        model_clear();
        #1;
        checks++;
        if ({N_out, k_out, ready_out, underrun_out} !== {VW{1'b0}}) begin
            errors++;
            $display("FAIL reset_outputs got %h expected 0", {N_out, k_out, ready_out, underrun_out});
        end
        rst = 1'b1;
    endtask

    task automatic test_basic_load();
        do_reset();
        for (int i = 0; i < NB; i++) step(0, 1, 0, RS'(i + 1), 0, 0);
        step(0, 1, 0, 32'd99, 0, 0);
        for (int i = 0; i < NB; i++) begin
            checks++;
            if (ready_out !== 1'b0) begin
                errors++;
                $display("FAIL early_ready got %b expected 0 before k block %0d", ready_out, i);
            end
            step(0, 1, 1, RS'(32'hA + i), 0, 0);
        end
        checks++;
        if (ready_out !== 1'b1 || N_out !== 32'd1 || k_out !== 32'hA) begin
            errors++;
            $display("FAIL load_ready got rdy=%b N=%h k=%h expected 1/1/a", ready_out, N_out, k_out);
        end
    endtask

    task automatic test_consume_n();
        logic [RS-1:0] seq [5];
        seq = '{32'd2, 32'd3, 32'd4, 32'd1, 32'd2};
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, '0, 1, 0);
            checks++;
            if (N_out !== seq[i] || k_out !== 32'hA) begin
                errors++;
                $display("FAIL consume_n[%0d] got N=%h k=%h expected N=%h k=a", i, N_out, k_out, seq[i]);
            end
        end
`ifdef MONT_CONST_PASS_CNT_EN
        checks++;
        if (N_pass_cnt_out !== 16'd1 || k_pass_cnt_out !== 16'd0) begin
            errors++;
            $display("FAIL pass_cnt got N=%0d k=%0d expected 1/0", N_pass_cnt_out, k_pass_cnt_out);
        end
`endif
    endtask

    task automatic test_interleave_both();
        logic [RS-1:0] nd [NB];
        logic [RS-1:0] kd [NB];
        int in_n;
        int in_k;
        bit sel;
        do_reset();
        for (int i = 0; i < NB; i++) begin
            nd[i] = $urandom;
            kd[i] = $urandom;
        end
        in_n = 0;
        in_k = 0;
        while (in_n < NB || in_k < NB) begin
            sel = (in_n == NB) ? 1'b1 : (in_k == NB) ? 1'b0 : 1'($urandom_range(0, 1));
            if (sel) begin
                step(0, 1, 1, kd[in_k], 0, 0);
                in_k++;
            end else begin
                step(0, 1, 0, nd[in_n], 0, 0);
                in_n++;
            end
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, '0, 1, 1);
            checks++;
            if (N_out !== nd[(i + 1) % NB] || k_out !== kd[(i + 1) % NB]) begin
                errors++;
                $display("FAIL both_consume[%0d] got N=%h k=%h expected N=%h k=%h",
                         i, N_out, k_out, nd[(i + 1) % NB], kd[(i + 1) % NB]);
            end
        end
    endtask

    task automatic test_underrun();
        logic [RS-1:0] kd [NB];
        do_reset();
        for (int i = 0; i < NB; i++) kd[i] = $urandom;
        step(0, 1, 0, $urandom, 0, 0);
        step(0, 1, 0, $urandom, 0, 0);
        step(0, 0, 0, '0, 0, 1);
        checks++;
        if (underrun_out !== 1'b1 || ready_out !== 1'b0) begin
            errors++;
            $display("FAIL underrun_set got und=%b rdy=%b expected 1/0", underrun_out, ready_out);
        end
        step(0, 1, 0, $urandom, 0, 0);
        step(0, 1, 0, $urandom, 0, 0);
        for (int i = 0; i < NB; i++) step(0, 1, 1, kd[i], 0, 0);
        checks++;
        if (k_out !== kd[0] || underrun_out !== 1'b1 || ready_out !== 1'b1) begin
            errors++;
            $display("FAIL underrun_after_load got k=%h und=%b rdy=%b expected k=%h 1/1",
                     k_out, underrun_out, ready_out, kd[0]);
        end
    endtask

    task automatic test_start_override();
        step(1, 1, 0, 32'd77, 1, 0);
        checks++;
        if (ready_out !== 1'b0 || N_out !== '0 || underrun_out !== 1'b0) begin
            errors++;
            $display("FAIL start_clear got rdy=%b N=%h und=%b expected 0/0/0", ready_out, N_out, underrun_out);
        end
        for (int i = 0; i < NB; i++) step(0, 1, 0, RS'(5 + i), 0, 0);
        for (int i = 0; i < NB; i++) step(0, 1, 1, RS'(32'hE + i), 0, 0);
        checks++;
        if (N_out !== 32'd5 || k_out !== 32'hE || ready_out !== 1'b1) begin
            errors++;
            $display("FAIL reload got N=%h k=%h rdy=%b expected 5/e/1", N_out, k_out, ready_out);
        end
    endtask

    task automatic test_random();
        bit s;
        for (int i = 0; i < 600; i++) begin
            s = ($urandom_range(0, 59) == 0);
            step(s, $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), $urandom,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
            checks++;
            if ({N_out, k_out, ready_out, underrun_out} !== expv()) begin
                errors++;
                $display("FAIL random[%0d] got %h expected %h", i,
                         {N_out, k_out, ready_out, underrun_out}, expv());
            end
`ifdef MONT_CONST_PASS_CNT_EN
            checks++;
            if (N_pass_cnt_out !== exp_pass(mcn) || k_pass_cnt_out !== exp_pass(mck)) begin
                errors++;
                $display("FAIL random_pass[%0d] got %0d/%0d expected %0d/%0d", i,
                         N_pass_cnt_out, k_pass_cnt_out, exp_pass(mcn), exp_pass(mck));
            end
`endif
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int i = 0; i < NB; i++) step(0, 1, 0, $urandom, 0, 0);
        for (int i = 0; i < NB; i++) step(0, 1, 1, $urandom, 0, 0);
        step(0, 0, 0, '0, 1, 1);
        step(0, 0, 0, '0, 1, 0);
        checks++;
        if ({N_out, k_out, ready_out, underrun_out} !== expv()) begin
            errors++;
            $display("FAIL pre_reset_stream got %h expected %h", {N_out, k_out, ready_out, underrun_out}, expv());
        end
        do_reset();
        checks++;
        if ({N_out, k_out, ready_out, underrun_out} !== {VW{1'b0}}) begin
            errors++;
            $display("FAIL midstream_reset got %h expected 0", {N_out, k_out, ready_out, underrun_out});
        end
        step(0, 0, 0, '0, 1, 1);
        checks++;
        if (ready_out !== 1'b0 || underrun_out !== 1'b1 || N_out !== '0) begin
            errors++;
            $display("FAIL no_resume got rdy=%b und=%b N=%h expected 0/1/0", ready_out, underrun_out, N_out);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_basic_load();
        test_consume_n();
        test_interleave_both();
        test_underrun();
        test_start_override();
        test_random();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
